// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, LSB first, one-entry stream output register
// with single-cycle framing-error and overrun pulses.
module uart_rx #(
    parameter int clk_rate = 100000000,
    parameter int Baud     = 115200,
    parameter int Word_len = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Uart_rx,
    output logic [Word_len-1:0] rx_data,
    output logic                rx_data_valid,
    input  logic                rx_data_ready,
    output logic                rx_frame_err,
    output logic                rx_overrun
);

    localparam int DIV  = clk_rate / Baud;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV) + 1;
    localparam int BW   = $clog2(Word_len + 1);

    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(Word_len - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]          state;
    logic [CW-1:0]       cnt;
    logic [BW-1:0]       bit_cnt;
    logic [Word_len-1:0] shreg;
    logic                rx_m, rx_s, rx_p;

    logic stop_tick, load, accept;

    // Synchronizer and edge-detect flops reset to the idle-high line level so
    // leaving reset never looks like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make each flop capture the previous
            // stage's old value, which is what turns these lines into a shift chain.
            rx_m <= Uart_rx;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    if (!rx_s && rx_p) state <= START;
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == DIV_M1) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[Word_len-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // Returning to IDLE at mid-stop leaves half a bit to catch the next start edge.
                    if (cnt == DIV_M1) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign stop_tick = (state == STOP) && (cnt == DIV_M1);
    assign accept    = rx_data_valid && rx_data_ready;
    assign load      = stop_tick && rx_s && (!rx_data_valid || rx_data_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_frame_err <= stop_tick && !rx_s;
            rx_overrun   <= stop_tick && rx_s && rx_data_valid && !rx_data_ready;
            if (load) begin
                rx_data       <= shreg;
                rx_data_valid <= 1'b1;
            end else if (accept) begin
                rx_data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: frame-level reference model with an
// expected-byte queue and expected error/overrun pulse counts.
module tb_uart_rx;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       Uart_rx;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       rx_frame_err;
    logic       rx_overrun;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int         exp_ferr = 0, exp_ovr = 0;
    int         ferr_cnt = 0, ovr_cnt = 0;
    logic       model_full = 1'b0;

    uart_rx #(.clk_rate(16), .Baud(1), .Word_len(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .Uart_rx      (Uart_rx),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame-level model: decide the fate of a frame from its stop bit and whether
    // the output register is still occupied by an unconsumed byte.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        if (!stop_bit) begin
            exp_ferr++;
        end else if (model_full) begin
            exp_ovr++;
        end else begin
            exp_q.push_back(b);
            model_full = !rx_data_ready;
        end
        Uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            Uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        Uart_rx = stop_bit;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        Uart_rx = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic check_totals(input string tag);
        repeat (4) @(negedge clk);
        check({tag, "_ferr"}, ferr_cnt, exp_ferr);
        check({tag, "_ovr"}, ovr_cnt, exp_ovr);
        check({tag, "_pending"}, exp_q.size(), (model_full ? 1 : 0));
    endtask

    // Monitor: sample on falling edge, score accepts, count pulses, check holding rules.
    logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;
    logic [7:0] prev_data = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", rx_data_valid, 1'b1);
                check("hold_data", rx_data, prev_data);
            end
            if (rx_data_valid && rx_data_ready && !model_full) begin
                if (exp_q.size() == 0) check("unexpected_byte", rx_data, 32'hFFFF_FFFF);
                else check("rx_data", rx_data, exp_q.pop_front());
            end
            if (rx_frame_err) begin
                ferr_cnt++;
                check("ferr_1cyc", prev_ferr, 1'b0);
            end
            if (rx_overrun) begin
                ovr_cnt++;
                check("ovr_1cyc", prev_ovr, 1'b0);
            end
        end
        prev_valid = rx_data_valid;
        prev_ready = rx_data_ready;
        prev_data  = rx_data;
        prev_ferr  = rx_frame_err;
        prev_ovr   = rx_overrun;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        Uart_rx = 1'b1;
        rx_data_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_data_valid, 1'b0);
        check("rst_ferr", rx_frame_err, 1'b0);
        check("rst_ovr", rx_overrun, 1'b0);
        rst = 1'b0;
        idle(2 * DIV);

        // Single frame, then back-to-back frames with no idle gap.
        send_frame(8'hA5, 1'b1);
        idle(DIV);
        check_totals("a5");
        send_frame(8'h3C, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(DIV);
        check_totals("b2b");

        // Consumer stalled: first byte held, second one overruns.
        rx_data_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(DIV);
        check("stall_valid", rx_data_valid, 1'b1);
        check("stall_data", rx_data, 8'h11);
        check_totals("stall");
        model_full = 1'b0;
        rx_data_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("drain_valid", rx_data_valid, 1'b0);
        check_totals("drain");

        // Bad stop bit, then a long break, then a clean frame.
        send_frame(8'h55, 1'b0);
        Uart_rx = 1'b0;
        repeat (5 * 10 * DIV) @(negedge clk);
        check("break_valid", rx_data_valid, 1'b0);
        check_totals("break");
        idle(2 * DIV);
        send_frame(8'h80, 1'b1);
        idle(DIV);
        check_totals("after_break");

        // Short low glitch on the idle line.
        Uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(3 * DIV);
        check("glitch_valid", rx_data_valid, 1'b0);
        check_totals("glitch");

        // Reset in the middle of the data bits of 0x5A.
        Uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            Uart_rx = 8'h5A >> i;
            repeat (DIV) @(negedge clk);
        end
        rst = 1'b1;
        Uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_valid", rx_data_valid, 1'b0);
        check("midrst_data", rx_data, 8'h00);
        rst = 1'b0;
        idle(2 * DIV);
        send_frame(8'hC3, 1'b1);
        idle(DIV);
        check_totals("midrst");

        // Randomized traffic: random bytes, gaps, occasional bad stop bits.
        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            logic       good;
            b    = 8'($urandom);
            good = ($urandom_range(0, 7) != 0);
            send_frame(b, good);
            if (!good) idle(DIV + $urandom_range(0, DIV));
            else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3 * DIV));
        end
        idle(DIV);
        check_totals("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that pairs with the team's AXI-Stream-fed UART transmitter. It samples the serial line at mid-bit and assembles 8N1 frames, LSB first. Each good byte is presented on an AXI-Stream-style master output, held in a one-entry output register. Framing errors and overruns are reported as single-cycle pulses. It sits between the chip's serial input pin and the downstream stream consumer.

Parameters:
clk_rate, 100000000, system clock frequency in Hz
Baud, 115200, line rate in bits/s
Word_len, 8, data bits per frame

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
Uart_rx  input  1  serial line, asynchronous to clk, idle high
rx_data  output  Word_len  received byte, LSB = first data bit on line
rx_data_valid  output  1  rx_data holds an unconsumed byte
rx_data_ready  input  1  consumer accepts byte when high with rx_data_valid
rx_frame_err  output  1  one-cycle pulse: stop bit sampled low
rx_overrun  output  1  one-cycle pulse: good byte dropped, output register still full

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Outputs under reset: rx_data=0, rx_data_valid=0, rx_frame_err=0, rx_overrun=0. Internally: state=IDLE, counters=0, synchronizer flops=1, previous-sample flop=1.
- Derived constants: DIV = clk_rate/Baud (integer divide); HALF = DIV/2. DIV >= 4 is required.
- Baud counter is $clog2(DIV)+1 bits wide and never exceeds DIV-1. Bit counter is $clog2(Word_len+1) bits wide.
- Uart_rx passes through a 2-flop synchronizer to give rx_s. rx_p is rx_s delayed by one cycle.
- IDLE:
  - Counters held at 0.
  - Start is detected only on a falling edge (rx_s=0 and rx_p=1), then go to START. A line held low (break) never retriggers.
- START:
  - Counter counts 0..HALF-1.
  - At HALF-1: if rx_s=0, go to DATA with counter=0; otherwise it was a glitch, return to IDLE with no pulse.
- DATA:
  - Counter counts 0..DIV-1. At DIV-1, rx_s is shifted into the MSB of the shift register (shift right) and bit_cnt increments.
  - After the Word_len-th sample, bit_cnt=0, go to STOP.
- STOP:
  - Counter counts 0..DIV-1. At DIV-1, rx_s is sampled and the state returns to IDLE.
  - Sample=1 and (rx_data_valid=0 or rx_data_ready=1 in that cycle): rx_data gets the shift register, rx_data_valid=1 from the next cycle.
  - Sample=1 and output full and not being drained: byte dropped, rx_overrun=1 for one cycle, held rx_data unchanged.
  - Sample=0: byte dropped, rx_frame_err=1 for one cycle, output register untouched.
- Output handshake:
  - rx_data_valid and rx_data are stable until the consumer accepts (rx_data_valid=1 and rx_data_ready=1).
  - On accept with no simultaneous load, rx_data_valid drops next cycle. A simultaneous accept and load keeps valid=1 with the new data.
  - rx_data_ready may be high without valid; this has no effect. Valid does not depend combinationally on ready.
- Latency: rx_data_valid rises one cycle after the stop-bit mid-sample.
- Reset mid-frame: the partial byte is discarded, no error pulse is issued, and reception restarts on the next falling edge.
- Back-to-back frames: returning to IDLE at mid-stop leaves half a bit to detect the next start edge, so there is no frame loss at full rate.

Test Plan:
- clk_rate=16, Baud=1 (DIV=16), send 0xA5 8N1, ready=1 -> rx_data=0xA5, valid for 1 cycle, frame_err=0, overrun=0.
- Send 0x3C then 0xFF back-to-back (no idle gap), ready=1 -> two accepts, 0x3C then 0xFF, no pulses.
- ready=0, send 0x11 then 0x22 -> valid=1 with 0x11 held, overrun pulses once at the second stop sample. Raise ready -> 0x11 accepted, valid drops.
- Send 0x55 with stop bit driven low -> frame_err single pulse, valid stays 0. Hold line low 5 frames -> no further starts or pulses. Release high, send 0x80 -> rx_data=0x80.
- Low glitch of 4 cycles on idle line -> return to IDLE, no valid, no pulses.
- Assert rst mid-DATA of 0x5A, release, send 0xC3 -> only 0xC3 delivered, no error pulses.
